// File: rtl/system_controller_pkg.sv
// Shared definitions for the register-file arbiter: FSM state encoding,
// requester IDs and the address-width helper.
package system_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_READ_WAIT = 2'd2
    } arb_state_t;

    localparam logic REQ_R0 = 1'b0;
    localparam logic REQ_R1 = 1'b1;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational two-way round-robin winner selection; on a tie the
// requester that did not own the previous access wins.
module round_robin_picker
    import system_controller_pkg::*;
(
    input  logic request0,
    input  logic request1,
    input  logic last_owner,
    output logic any_request,
    output logic winner
);

    // Pick the winner from the live requests and the previous owner.
    always_comb begin
        any_request = request0 | request1;
        if (request0 && request1) begin
            winner = ~last_owner;
        end else if (request1) begin
            winner = REQ_R1;
        end else begin
            winner = REQ_R0;
        end
    end

endmodule

// File: rtl/register_file_arbiter.sv
// Round-robin arbiter sharing one register-file port between r0 and r1.
// Optional read abort after TIMEOUT_CYCLES is enabled by REGFILE_ARB_TIMEOUT_EN.
module register_file_arbiter
    import system_controller_pkg::*;
#(
    parameter int  DATA_WIDTH          = 8,
    parameter int  REGISTER_FILE_DEPTH = 16,
    parameter int  TIMEOUT_CYCLES      = 15,
    localparam int ADDR_W              = addr_w(REGISTER_FILE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_request,
    input  logic                  r1_request,
    input  logic                  r0_write,
    input  logic                  r1_write,
    input  logic [ADDR_W-1:0]     r0_address,
    input  logic [ADDR_W-1:0]     r1_address,
    input  logic [DATA_WIDTH-1:0] r0_write_data,
    input  logic [DATA_WIDTH-1:0] r1_write_data,
    output logic                  r0_grant,
    output logic                  r1_grant,
    output logic                  r0_read_data_valid,
    output logic                  r1_read_data_valid,
    output logic [DATA_WIDTH-1:0] r0_read_data,
    output logic [DATA_WIDTH-1:0] r1_read_data,
    output logic                  read_timeout,
    output logic [ADDR_W-1:0]     register_file_address,
    output logic                  register_file_write_enable,
    output logic [DATA_WIDTH-1:0] register_file_write_data,
    output logic                  register_file_read_enable,
    input  logic                  register_file_read_data_valid,
    input  logic [DATA_WIDTH-1:0] register_file_read_data
);

    arb_state_t            state_r;
    arb_state_t            state_next_s;
    logic                  last_owner_r;
    logic                  owner_r;
    logic                  write_r;
    logic                  any_request_s;
    logic                  winner_s;
    logic                  winner_write_s;
    logic [ADDR_W-1:0]     winner_address_s;
    logic [DATA_WIDTH-1:0] winner_data_s;
    logic                  latch_s;
    logic                  capture_s;
    logic                  timeout_s;
    logic                  timeout_hit_s;
    logic                  deliver_s;

    round_robin_picker u_picker (
        .request0    (r0_request),
        .request1    (r1_request),
        .last_owner  (last_owner_r),
        .any_request (any_request_s),
        .winner      (winner_s)
    );

    // Steer the winning requester's command onto the latch inputs.
    always_comb begin
        if (winner_s == REQ_R1) begin
            winner_write_s   = r1_write;
            winner_address_s = r1_address;
            winner_data_s    = r1_write_data;
        end else begin
            winner_write_s   = r0_write;
            winner_address_s = r0_address;
            winner_data_s    = r0_write_data;
        end
    end

`ifdef REGFILE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_count_r;

    // Count READ_WAIT cycles; held at zero elsewhere so every wait starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_count_r <= {CNT_W{1'b0}};
        end else if (state_r != ST_READ_WAIT) begin
            wait_count_r <= {CNT_W{1'b0}};
        end else begin
            wait_count_r <= wait_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign timeout_hit_s = (wait_count_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state logic and the per-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_request_s) begin
                    latch_s      = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (write_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                if (register_file_read_data_valid) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (timeout_hit_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_READ_WAIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign deliver_s = capture_s | timeout_s;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command latch, registered strobes and read-data return; strobes are
    // computed one cycle early so they are high exactly during ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_r               <= REQ_R1;
            owner_r                    <= REQ_R0;
            write_r                    <= 1'b0;
            r0_grant                   <= 1'b0;
            r1_grant                   <= 1'b0;
            register_file_write_enable <= 1'b0;
            register_file_read_enable  <= 1'b0;
            register_file_address      <= {ADDR_W{1'b0}};
            register_file_write_data   <= {DATA_WIDTH{1'b0}};
            r0_read_data_valid         <= 1'b0;
            r1_read_data_valid         <= 1'b0;
            r0_read_data               <= {DATA_WIDTH{1'b0}};
            r1_read_data               <= {DATA_WIDTH{1'b0}};
            read_timeout               <= 1'b0;
        end else begin
            r0_grant                   <= latch_s & (winner_s == REQ_R0);
            r1_grant                   <= latch_s & (winner_s == REQ_R1);
            register_file_write_enable <= latch_s & winner_write_s;
            register_file_read_enable  <= latch_s & ~winner_write_s;
            r0_read_data_valid         <= deliver_s & (owner_r == REQ_R0);
            r1_read_data_valid         <= deliver_s & (owner_r == REQ_R1);
            read_timeout               <= timeout_s;
            if (latch_s) begin
                owner_r                  <= winner_s;
                last_owner_r             <= winner_s;
                write_r                  <= winner_write_s;
                register_file_address    <= winner_address_s;
                register_file_write_data <= winner_data_s;
            end
            if (deliver_s && (owner_r == REQ_R0)) begin
                r0_read_data <= capture_s ? register_file_read_data : {DATA_WIDTH{1'b1}};
            end
            if (deliver_s && (owner_r == REQ_R1)) begin
                r1_read_data <= capture_s ? register_file_read_data : {DATA_WIDTH{1'b1}};
            end
        end
    end

endmodule

// File: tb/tb_register_file_arbiter.sv
// Self-checking bench for register_file_arbiter: directed table, corner
// sequences, then randomized traffic against a cycle-arithmetic reference model.
module tb_register_file_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       r0_request, r1_request, r0_write, r1_write;
    logic [3:0] r0_address, r1_address;
    logic [7:0] r0_write_data, r1_write_data;
    logic       r0_grant, r1_grant, r0_read_data_valid, r1_read_data_valid;
    logic [7:0] r0_read_data, r1_read_data;
    logic       read_timeout;
    logic [3:0] register_file_address;
    logic       register_file_write_enable, register_file_read_enable;
    logic [7:0] register_file_write_data;
    logic       register_file_read_data_valid;
    logic [7:0] register_file_read_data;

    int n_checks = 0;
    int n_pass   = 0;

    register_file_arbiter dut (
        .clk                           (clk),
        .reset                         (reset),
        .r0_request                    (r0_request),
        .r1_request                    (r1_request),
        .r0_write                      (r0_write),
        .r1_write                      (r1_write),
        .r0_address                    (r0_address),
        .r1_address                    (r1_address),
        .r0_write_data                 (r0_write_data),
        .r1_write_data                 (r1_write_data),
        .r0_grant                      (r0_grant),
        .r1_grant                      (r1_grant),
        .r0_read_data_valid            (r0_read_data_valid),
        .r1_read_data_valid            (r1_read_data_valid),
        .r0_read_data                  (r0_read_data),
        .r1_read_data                  (r1_read_data),
        .read_timeout                  (read_timeout),
        .register_file_address         (register_file_address),
        .register_file_write_enable    (register_file_write_enable),
        .register_file_write_data      (register_file_write_data),
        .register_file_read_enable     (register_file_read_enable),
        .register_file_read_data_valid (register_file_read_data_valid),
        .register_file_read_data       (register_file_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_request = 1'b0; r1_request = 1'b0; r0_write = 1'b0; r1_write = 1'b0;
        r0_address = 4'h0; r1_address = 4'h0; r0_write_data = 8'h00; r1_write_data = 8'h00;
        register_file_read_data_valid = 1'b0; register_file_read_data = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grants"}, {30'd0, r0_grant, r1_grant}, 32'd0);
        check({tag, "_strobes"}, {30'd0, register_file_write_enable, register_file_read_enable}, 32'd0);
        check({tag, "_valids"}, {29'd0, r0_read_data_valid, r1_read_data_valid, read_timeout}, 32'd0);
        check({tag, "_addr"}, {28'd0, register_file_address}, 32'd0);
        check({tag, "_wdata"}, {24'd0, register_file_write_data}, 32'd0);
        check({tag, "_rdata"}, {16'd0, r0_read_data, r1_read_data}, 32'd0);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
    endtask

    typedef struct {
        logic       q0, q1;
        logic [3:0] a0, a1;
        logic [7:0] d0, d1;
        logic       eg0, eg1;
        logic [3:0] ea;
        logic [7:0] ed;
    } vec_t;
    vec_t tbl[8];

    // Reference-model state for the randomized phase
    int         free_edge, wait_from, resp_edge;
    bit         waiting, spur;
    logic       m_last, m_owner, win;
    logic       eg0, eg1, ewe, ere, ev0, ev1;
    logic [3:0] e_addr;
    logic [7:0] e_wdata, e_rd0, e_rd1;
    int         n, seen;

    initial begin
        // Writes from reset (last owner r1): single requests and ties.
        tbl[0] = '{1'b1, 1'b0, 4'h3, 4'h0, 8'hA5, 8'h00, 1'b1, 1'b0, 4'h3, 8'hA5};
        tbl[1] = '{1'b1, 1'b1, 4'h1, 4'h2, 8'h11, 8'h22, 1'b0, 1'b1, 4'h2, 8'h22};
        tbl[2] = '{1'b1, 1'b1, 4'h4, 4'h6, 8'h44, 8'h66, 1'b1, 1'b0, 4'h4, 8'h44};
        tbl[3] = '{1'b0, 1'b1, 4'h0, 4'hF, 8'h00, 8'hFF, 1'b0, 1'b1, 4'hF, 8'hFF};
        tbl[4] = '{1'b0, 1'b1, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00};
        tbl[5] = '{1'b1, 1'b1, 4'h8, 4'h9, 8'h88, 8'h99, 1'b1, 1'b0, 4'h8, 8'h88};
        tbl[6] = '{1'b1, 1'b0, 4'hA, 4'h0, 8'hAA, 8'h00, 1'b1, 1'b0, 4'hA, 8'hAA};
        tbl[7] = '{1'b1, 1'b1, 4'hC, 4'hD, 8'hCC, 8'hDD, 1'b0, 1'b1, 4'hD, 8'hDD};

        do_reset();
        tick();
        for (int i = 0; i < 8; i++) begin
            r0_request = tbl[i].q0; r1_request = tbl[i].q1;
            r0_write = 1'b1; r1_write = 1'b1;
            r0_address = tbl[i].a0; r1_address = tbl[i].a1;
            r0_write_data = tbl[i].d0; r1_write_data = tbl[i].d1;
            tick();
            check($sformatf("tbl%0d_grant", i), {30'd0, r0_grant, r1_grant}, {30'd0, tbl[i].eg0, tbl[i].eg1});
            check($sformatf("tbl%0d_strobe", i), {30'd0, register_file_write_enable, register_file_read_enable}, 32'd2);
            check($sformatf("tbl%0d_addr", i), {28'd0, register_file_address}, {28'd0, tbl[i].ea});
            check($sformatf("tbl%0d_wdata", i), {24'd0, register_file_write_data}, {24'd0, tbl[i].ed});
            r0_request = 1'b0; r1_request = 1'b0;
            tick();
            check($sformatf("tbl%0d_idle", i), {28'd0, r0_grant, r1_grant, register_file_write_enable, register_file_read_enable}, 32'd0);
            check($sformatf("tbl%0d_hold", i), {20'd0, register_file_address, register_file_write_data}, {20'd0, tbl[i].ea, tbl[i].ed});
        end

        // r1 read of address 5, data returned two cycles after the strobe
        r1_request = 1'b1; r1_write = 1'b0; r1_address = 4'h5;
        tick();
        check("rd_issue", {27'd0, r1_grant, r0_grant, register_file_read_enable, register_file_write_enable, 1'b0}, {27'd0, 5'b10100});
        check("rd_addr", {28'd0, register_file_address}, 32'd5);
        r1_request = 1'b0;
        tick();
        check("rd_wait_novalid", {30'd0, r0_read_data_valid, r1_read_data_valid}, 32'd0);
        register_file_read_data_valid = 1'b1; register_file_read_data = 8'h3C;
        tick();
        register_file_read_data_valid = 1'b0; register_file_read_data = 8'h00;
        check("rd_r1_valid", {31'd0, r1_read_data_valid}, 32'd1);
        check("rd_r1_data", {24'd0, r1_read_data}, 32'h3C);
        check("rd_r0_untouched", {23'd0, r0_read_data_valid, r0_read_data}, 32'd0);
        tick();
        check("rd_valid_pulse", {31'd0, r1_read_data_valid}, 32'd0);
        check("rd_data_held", {24'd0, r1_read_data}, 32'h3C);

        // Spurious read-data valid while idle is ignored
        register_file_read_data_valid = 1'b1; register_file_read_data = 8'h77;
        tick();
        register_file_read_data_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("spur_novalid", {30'd0, r0_read_data_valid, r1_read_data_valid}, 32'd0);
        end
        check("spur_data", {16'd0, r0_read_data, r1_read_data}, 32'h003C);

        // Both requesting continuously from reset: r0, r1, r0, r1
        do_reset();
        r0_request = 1'b1; r0_write = 1'b1; r0_address = 4'h1; r0_write_data = 8'h10;
        r1_request = 1'b1; r1_write = 1'b1; r1_address = 4'h2; r1_write_data = 8'h20;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rr%0d_grant", i), {30'd0, r0_grant, r1_grant},
                  (i % 4 == 0) ? 32'd2 : ((i % 4 == 2) ? 32'd1 : 32'd0));
            check($sformatf("rr%0d_strobe", i), {30'd0, register_file_write_enable, register_file_read_enable},
                  (i % 2 == 0) ? 32'd2 : 32'd0);
            if (i % 2 == 0) begin
                check($sformatf("rr%0d_addr", i), {28'd0, register_file_address}, (i % 4 == 0) ? 32'd1 : 32'd2);
            end
        end
        clear_inputs();

        // Reset in the middle of a read wait; late data must not be forwarded
        do_reset();
        tick();
        r0_request = 1'b1; r0_write = 1'b0; r0_address = 4'h7;
        tick();
        check("mid_issue", {28'd0, register_file_address}, 32'd7);
        r0_request = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #2;
        check_all_zero("mid_async");
        tick();
        reset = 1'b1;
        register_file_read_data_valid = 1'b1; register_file_read_data = 8'h5A;
        tick();
        register_file_read_data_valid = 1'b0;
        tick();
        check_all_zero("mid_after");

        // Read that never gets data
        r1_request = 1'b1; r1_write = 1'b0; r1_address = 4'h9;
        tick();
        check("to_issue", {30'd0, r1_grant, register_file_read_enable}, 32'd3);
        r1_request = 1'b0;
`ifdef REGFILE_ARB_TIMEOUT_EN
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (read_timeout) begin
                n = i;
                break;
            end
        end
        check("to_latency", n, 32'd16);
        check("to_owner", {30'd0, r1_read_data_valid, r0_read_data_valid}, 32'd2);
        check("to_data", {24'd0, r1_read_data}, 32'hFF);
        tick();
        check("to_pulse", {30'd0, read_timeout, r1_read_data_valid}, 32'd0);
        register_file_read_data_valid = 1'b1; register_file_read_data = 8'h42;
        tick();
        register_file_read_data_valid = 1'b0;
        check("to_late_ignored", {23'd0, r1_read_data_valid, r1_read_data}, 32'h0FF);
`else
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (r1_read_data_valid || read_timeout) seen++;
        end
        check("nto_waiting", seen, 32'd0);
        register_file_read_data_valid = 1'b1; register_file_read_data = 8'h42;
        tick();
        register_file_read_data_valid = 1'b0;
        check("nto_delivered", {23'd0, r1_read_data_valid, r1_read_data}, 32'h142);
`endif
        tick();

        // Randomized traffic vs. reference model (arithmetic on edge numbers)
        do_reset();
        free_edge = 0; waiting = 1'b0; resp_edge = -1; m_last = 1'b1; m_owner = 1'b0;
        e_addr = 4'h0; e_wdata = 8'h00; e_rd0 = 8'h00; e_rd1 = 8'h00;
        for (int k = 0; k < 1500; k++) begin
            eg0 = 1'b0; eg1 = 1'b0; ewe = 1'b0; ere = 1'b0; ev0 = 1'b0; ev1 = 1'b0;
            if (!waiting && k >= free_edge && (r0_request || r1_request)) begin
                win = (r0_request && r1_request) ? !m_last : r1_request;
                m_last = win;
                eg0 = !win; eg1 = win;
                ewe = win ? r1_write : r0_write;
                ere = !ewe;
                e_addr = win ? r1_address : r0_address;
                e_wdata = win ? r1_write_data : r0_write_data;
                if (ewe) begin
                    free_edge = k + 2;
                end else begin
                    waiting = 1'b1; wait_from = k + 2; m_owner = win;
                end
            end else if (waiting && k >= wait_from && register_file_read_data_valid) begin
                waiting = 1'b0; free_edge = k + 1;
                if (m_owner) begin ev1 = 1'b1; e_rd1 = register_file_read_data; end
                else begin ev0 = 1'b1; e_rd0 = register_file_read_data; end
            end
            tick();
            check("rnd_grant", {30'd0, r0_grant, r1_grant}, {30'd0, eg0, eg1});
            check("rnd_strobe", {30'd0, register_file_write_enable, register_file_read_enable}, {30'd0, ewe, ere});
            check("rnd_addr", {28'd0, register_file_address}, {28'd0, e_addr});
            check("rnd_wdata", {24'd0, register_file_write_data}, {24'd0, e_wdata});
            check("rnd_valid", {29'd0, r0_read_data_valid, r1_read_data_valid, read_timeout}, {29'd0, ev0, ev1, 1'b0});
            check("rnd_rdata", {16'd0, r0_read_data, r1_read_data}, {16'd0, e_rd0, e_rd1});
            // Requesters hold until granted, then drop
            if (eg0) r0_request = 1'b0;
            else if (!r0_request && $urandom_range(0, 2) == 0) begin
                r0_request = 1'b1; r0_write = 1'($urandom_range(0, 1));
                r0_address = 4'($urandom); r0_write_data = 8'($urandom);
            end
            if (eg1) r1_request = 1'b0;
            else if (!r1_request && $urandom_range(0, 2) == 0) begin
                r1_request = 1'b1; r1_write = 1'($urandom_range(0, 1));
                r1_address = 4'($urandom); r1_write_data = 8'($urandom);
            end
            // Register-file responder with 1..3 cycles extra latency, plus stray valids
            if (ere) resp_edge = k + 1 + $urandom_range(1, 3);
            spur = (resp_edge <= k) && ($urandom_range(0, 9) == 0);
            register_file_read_data_valid = (resp_edge == k + 1) || spur;
            register_file_read_data = 8'($urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
